// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A-style interrupt controller slice.
package pic_pkg;

  localparam int NUM_IR      = 8;
  localparam int SPURIOUS_ID = 7;

  typedef logic [2:0] ir_id_t;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    ACK1,
    ACK2
  } pr_state_t;

endpackage

// File: rtl/prio_enc8.sv
// Lowest-set-bit encoder: bit 0 is the highest priority, valid flags any set bit.
module prio_enc8
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] bits,
  output ir_id_t            id,
  output logic              valid
);

  // Scan from the lowest-priority end so the highest-priority set bit wins last.
  always_comb begin
    id    = '0;
    valid = |bits;
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      if (bits[i]) id = ir_id_t'(i);
    end
  end

endmodule

// File: rtl/priority_resolver.sv
// Masks and prioritises requests against the in-service level, raises INT
// and runs the two-pulse INTA handshake that produces the vector byte.
module priority_resolver
  import pic_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IR-1:0] irr_in,
  input  logic [NUM_IR-1:0] imr,
  input  logic [NUM_IR-1:0] isr_cur,
  input  logic [4:0]        icw2_base,
  input  logic              inta,
  output logic              int_out,
  output logic [NUM_IR-1:0] isr_set,
  output logic [NUM_IR-1:0] irr_clear,
  output logic [7:0]        vector_out,
  output logic              vector_oe
);

  logic [NUM_IR-1:0] req;
  ir_id_t            win_id;
  ir_id_t            svc_id;
  logic              req_any;
  logic              svc_any;
  logic              req_valid;

  pr_state_t         state;
  pr_state_t         state_next;
  ir_id_t            id_q;
  ir_id_t            id_d;
  logic              first_ack;
  logic              second_ack;

  logic              int_d;
  logic [NUM_IR-1:0] isr_set_d;
  logic [NUM_IR-1:0] irr_clear_d;
  logic [7:0]        vector_d;
  logic              vector_oe_d;

  assign req = irr_in & ~imr;

  prio_enc8 u_req_enc (
    .bits  (req),
    .id    (win_id),
    .valid (req_any)
  );

  prio_enc8 u_svc_enc (
    .bits  (isr_cur),
    .id    (svc_id),
    .valid (svc_any)
  );

  // A request only counts if it strictly outranks the highest in-service level.
  assign req_valid  = req_any && (!svc_any || (win_id < svc_id));
  assign first_ack  = inta && ((state == IDLE) || (state == PEND));
  assign second_ack = inta && (state == ACK1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      id_q  <= '0;
    end else begin
      state <= state_next;
      id_q  <= id_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (inta)           state_next = ACK1;
        else if (req_valid) state_next = PEND;
      end
      PEND: begin
        if (inta)            state_next = ACK1;
        else if (!req_valid) state_next = IDLE;
      end
      ACK1: begin
        if (inta) state_next = ACK2;
      end
      ACK2: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The id is captured once at the first INTA and frozen through the handshake.
  always_comb begin
    id_d        = id_q;
    isr_set_d   = '0;
    irr_clear_d = '0;
    vector_d    = '0;
    vector_oe_d = 1'b0;
    int_d       = (state_next == PEND);
    if (first_ack) begin
      if (req_valid) begin
        id_d        = win_id;
        isr_set_d   = NUM_IR'(1) << win_id;
        irr_clear_d = NUM_IR'(1) << win_id;
      end else begin
        id_d = ir_id_t'(SPURIOUS_ID);
      end
    end
    if (second_ack) begin
      vector_d    = {icw2_base, id_q};
      vector_oe_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_out    <= 1'b0;
      isr_set    <= '0;
      irr_clear  <= '0;
      vector_out <= '0;
      vector_oe  <= 1'b0;
    end else begin
      int_out    <= int_d;
      isr_set    <= isr_set_d;
      irr_clear  <= irr_clear_d;
      vector_out <= vector_d;
      vector_oe  <= vector_oe_d;
    end
  end

endmodule

// File: tb/tb_priority_resolver.sv
// Scoreboard bench for priority_resolver: directed scenarios then random traffic
// against a priority-rule reference model.
module tb_priority_resolver;
  import pic_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] irr_in = '0;
  logic [7:0] imr = '0;
  logic [7:0] isr_cur = '0;
  logic [4:0] icw2_base = '0;
  logic       inta = 1'b0;
  logic       int_out;
  logic [7:0] isr_set;
  logic [7:0] irr_clear;
  logic [7:0] vector_out;
  logic       vector_oe;

  priority_resolver dut (
    .clk        (clk),
    .reset      (reset),
    .irr_in     (irr_in),
    .imr        (imr),
    .isr_cur    (isr_cur),
    .icw2_base  (icw2_base),
    .inta       (inta),
    .int_out    (int_out),
    .isr_set    (isr_set),
    .irr_clear  (irr_clear),
    .vector_out (vector_out),
    .vector_oe  (vector_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pulse;
    logic [7:0] vec;
  } txn_t;

  txn_t       sb_q[$];
  int         total = 0;
  int         bad = 0;

  int         phase = 0;
  logic       exp_int = 1'b0;
  logic [7:0] held_pulse = '0;
  int         held_id = 0;

  logic [7:0] pulse_acc = '0;
  int         pulse_cycles = 0;

  // Index of the highest-priority set bit, or 8 when none is set.
  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Checks int_out from the previous cycle, then drives one new cycle and advances the model.
  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] m, input logic [7:0] s,
                               input logic [4:0] b, input logic a);
    int  w;
    int  sv;
    bit  v;
    @(negedge clk);
    checkOutput("int_out", {31'd0, int_out}, {31'd0, exp_int});
    irr_in    = r;
    imr       = m;
    isr_cur   = s;
    icw2_base = b;
    inta      = a;
    w  = lowest(r & ~m);
    sv = lowest(s);
    v  = (w < 8) && (w < sv);
    case (phase)
      0: begin
        if (a) begin
          held_id    = v ? w : SPURIOUS_ID;
          held_pulse = v ? 8'(1 << w) : 8'h00;
          phase      = 1;
          exp_int    = 1'b0;
        end else begin
          exp_int = v;
        end
      end
      1: begin
        exp_int = 1'b0;
        if (a) begin
          sb_q.push_back('{pulse: held_pulse, vec: {b, 3'(held_id)}});
          phase = 2;
        end
      end
      default: begin
        exp_int = 1'b0;
        phase   = 0;
      end
    endcase
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(8'h00, 8'h00, 8'h00, 5'h01, 1'b0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    inta  = 1'b0;
    #1;
    checkOutput("rst_int_out", {31'd0, int_out}, 32'd0);
    checkOutput("rst_isr_set", {24'd0, isr_set}, 32'd0);
    checkOutput("rst_irr_clear", {24'd0, irr_clear}, 32'd0);
    checkOutput("rst_vector_out", {24'd0, vector_out}, 32'd0);
    checkOutput("rst_vector_oe", {31'd0, vector_oe}, 32'd0);
    sb_q.delete();
    phase   = 0;
    exp_int = 1'b0;
    irr_in  = '0;
    imr     = '0;
    isr_cur = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: collects in-service pulses and retires a scoreboard entry on each vector.
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      if (reset) begin
        pulse_acc    = '0;
        pulse_cycles = 0;
      end else begin
        if ((isr_set != 8'h00) || (irr_clear != 8'h00)) begin
          checkOutput("irr_clear_vs_isr_set", {24'd0, irr_clear}, {24'd0, isr_set});
          pulse_acc    = pulse_acc | isr_set;
          pulse_cycles = pulse_cycles + 1;
        end
        if (!vector_oe) begin
          checkOutput("vector_idle_zero", {24'd0, vector_out}, 32'd0);
        end else if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_vector: got 0x%0h expected none at %0t", vector_out, $time);
        end else begin
          t = sb_q.pop_front();
          checkOutput("vector_out", {24'd0, vector_out}, {24'd0, t.vec});
          checkOutput("isr_pulse", {24'd0, pulse_acc}, {24'd0, t.pulse});
          checkOutput("pulse_width", pulse_cycles, (t.pulse != 8'h00) ? 32'd1 : 32'd0);
          pulse_acc    = '0;
          pulse_cycles = 0;
        end
      end
    end
  end

  initial begin
    #1;
    doReset();

    $display("[TB] scenario: basic handshake");
    applyStimulus(8'h14, 8'h00, 8'h00, 5'h08, 1'b0);
    applyStimulus(8'h14, 8'h00, 8'h00, 5'h08, 1'b1);
    applyStimulus(8'h14, 8'h00, 8'h00, 5'h08, 1'b0);
    applyStimulus(8'h14, 8'h00, 8'h00, 5'h08, 1'b1);
    idle(4);

    $display("[TB] scenario: masked request");
    for (int k = 0; k < 20; k++) applyStimulus(8'h01, 8'h01, 8'h00, 5'h08, 1'b0);
    applyStimulus(8'h01, 8'h00, 8'h00, 5'h08, 1'b0);
    applyStimulus(8'h01, 8'h00, 8'h00, 5'h08, 1'b0);
    idle(3);

    $display("[TB] scenario: in-service blocking");
    for (int k = 0; k < 3; k++) applyStimulus(8'h08, 8'h00, 8'h04, 5'h08, 1'b0);
    applyStimulus(8'h0A, 8'h00, 8'h04, 5'h08, 1'b0);
    applyStimulus(8'h0A, 8'h00, 8'h04, 5'h08, 1'b1);
    applyStimulus(8'h0A, 8'h00, 8'h04, 5'h08, 1'b0);
    applyStimulus(8'h0A, 8'h00, 8'h04, 5'h08, 1'b1);
    idle(3);

    $display("[TB] scenario: spurious");
    applyStimulus(8'h10, 8'h00, 8'h00, 5'h11, 1'b0);
    applyStimulus(8'h00, 8'h00, 8'h00, 5'h11, 1'b0);
    applyStimulus(8'h00, 8'h00, 8'h00, 5'h11, 1'b1);
    applyStimulus(8'h00, 8'h00, 8'h00, 5'h11, 1'b0);
    applyStimulus(8'h00, 8'h00, 8'h00, 5'h11, 1'b1);
    idle(3);

    $display("[TB] scenario: id frozen between INTA pulses");
    applyStimulus(8'h80, 8'h00, 8'h00, 5'h1F, 1'b0);
    applyStimulus(8'h80, 8'h00, 8'h00, 5'h1F, 1'b1);
    applyStimulus(8'h01, 8'h00, 8'h00, 5'h1F, 1'b0);
    applyStimulus(8'h01, 8'h00, 8'h00, 5'h1F, 1'b1);
    applyStimulus(8'h01, 8'h00, 8'h00, 5'h1F, 1'b1);
    idle(3);

    $display("[TB] scenario: reset during second acknowledge");
    applyStimulus(8'h02, 8'h00, 8'h00, 5'h05, 1'b0);
    applyStimulus(8'h02, 8'h00, 8'h00, 5'h05, 1'b1);
    applyStimulus(8'h00, 8'h00, 8'h00, 5'h05, 1'b0);
    applyStimulus(8'h00, 8'h00, 8'h00, 5'h05, 1'b1);
    @(posedge clk);
    #2;
    doReset();
    idle(3);
    applyStimulus(8'h20, 8'h00, 8'h00, 5'h05, 1'b0);
    applyStimulus(8'h20, 8'h00, 8'h00, 5'h05, 1'b0);
    idle(3);

    $display("[TB] scenario: random traffic");
    for (int k = 0; k < 500; k++) begin
      logic [7:0] r;
      logic [7:0] m;
      logic [7:0] s;
      r = 8'($urandom);
      m = 8'($urandom) & 8'($urandom);
      s = ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      applyStimulus(r, m, s, 5'($urandom), ($urandom_range(0, 4) == 0));
    end
    idle(5);
    checkOutput("scoreboard_empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
